// File: rtl/app_stage_sequencer.sv
// Purpose: runs the six CGRA application stages in order, one request at a time, with a per-stage watchdog.
// Latency: START to first STEP_REQ is 1 cycle; each done adds a 1-cycle GAP; the last GAP is followed by 1 FIN cycle.
// Backpressure: a stage holds its level request until its done pulse, a watchdog timeout or ABORT. START while BUSY is ignored.
// Optional: `define APP_SEQ_PERF_CNT_EN adds the per-stage and total cycle counters.
module app_stage_sequencer #(
  parameter int CNT_W = 32,
  parameter int TMO_W = 24
) (
  input  logic             CPU_CLK,
  input  logic             CPU_RESETn,
  input  logic             START,
  input  logic             ABORT,
  input  logic [5:0]       SKIP_MASK,
  input  logic [TMO_W-1:0] TIMEOUT_LIMIT,
  output logic [5:0]       STEP_REQ,
  input  logic [5:0]       STEP_DONE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERROR,
  output logic [2:0]       ERR_STAGE,
  output logic [2:0]       STAGE,
  input  logic [2:0]       CNT_SEL,
  output logic [CNT_W-1:0] CNT_RDATA,
  output logic [CNT_W-1:0] TOTAL_CYCLES
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_FIN} state_t;

  state_t           state_q, state_d;
  logic [2:0]       stg_q, stg_d;
  logic [5:0]       skip_q;
  logic [TMO_W-1:0] limit_q;
  logic [TMO_W-1:0] wd_q;
  logic [TMO_W-1:0] wd_inc;
  logic             start_acc;
  logic             cur_done;
  logic             abort_hit;
  logic             timeout;
  logic [3:0]       nxt;
  logic [5:0]       req_d;
  logic             busy_d;
  logic             done_d;
  logic [2:0]       stage_d;

  // Lowest unskipped stage at or above 'from'; bit 3 flags that one exists.
  function automatic logic [3:0] find_next(input logic [5:0] mask, input logic [2:0] from);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 5; i >= 0; i--) begin
      if (!mask[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign start_acc = (state_q == ST_IDLE) && START;
  assign abort_hit = (state_q != ST_IDLE) && ABORT;
  assign cur_done  = (state_q == ST_REQ) && STEP_DONE[stg_q];
  // Watchdog value including the current REQ cycle, saturating.
  assign wd_inc    = (wd_q == '1) ? wd_q : wd_q + 1'b1;
  assign timeout   = (state_q == ST_REQ) && (limit_q != '0) && (wd_inc == limit_q) && !STEP_DONE[stg_q];

  // State register and current stage index.
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      state_q <= ST_IDLE;
      stg_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      stg_q   <= stg_d;
    end
  end

  // Next-state logic; ABORT beats done, done beats timeout.
  always_comb begin
    state_d = state_q;
    stg_d   = stg_q;
    nxt     = 4'b0000;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          nxt = find_next(SKIP_MASK, 3'd0);
          if (nxt[3]) begin
            state_d = ST_REQ;
            stg_d   = nxt[2:0];
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_REQ: begin
        if (ABORT)              state_d = ST_IDLE;
        else if (cur_done)      state_d = ST_GAP;
        else if (timeout)       state_d = ST_IDLE;
      end
      ST_GAP: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else begin
          nxt = find_next(skip_q, stg_q + 3'd1);
          if (nxt[3]) begin
            state_d = ST_REQ;
            stg_d   = nxt[2:0];
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode of the next state so every output leaves a flop.
  always_comb begin
    req_d   = 6'b000000;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_FIN);
    stage_d = 3'd7;
    if (state_d == ST_REQ) req_d[stg_d] = 1'b1;
    if ((state_d == ST_REQ) || (state_d == ST_GAP)) stage_d = stg_d;
  end

  // Registered control outputs; reset drops STEP_REQ immediately.
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      STEP_REQ <= 6'b000000;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      STAGE    <= 3'd7;
    end else begin
      STEP_REQ <= req_d;
      BUSY     <= busy_d;
      DONE     <= done_d;
      STAGE    <= stage_d;
    end
  end

  // Run configuration captured on an accepted START.
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      skip_q  <= 6'b000000;
      limit_q <= '0;
    end else if (start_acc) begin
      skip_q  <= SKIP_MASK;
      limit_q <= TIMEOUT_LIMIT;
    end
  end

  // Watchdog counts REQ cycles of the current stage; cleared at start and in GAP.
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      wd_q <= '0;
    end else if (start_acc || (state_q == ST_GAP)) begin
      wd_q <= '0;
    end else if (state_q == ST_REQ) begin
      wd_q <= wd_inc;
    end
  end

  // Sticky error flag and failing stage; 7 marks an abort.
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      ERROR     <= 1'b0;
      ERR_STAGE <= 3'd0;
    end else if (start_acc) begin
      ERROR     <= 1'b0;
    end else if (abort_hit) begin
      ERROR     <= 1'b1;
      ERR_STAGE <= 3'd7;
    end else if (timeout) begin
      ERROR     <= 1'b1;
      ERR_STAGE <= stg_q;
    end
  end

`ifdef APP_SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] stage_cnt_q [6];
  logic [CNT_W-1:0] total_q;

  // Saturating per-stage REQ-cycle counters and BUSY-cycle total, cleared on START.
  always_ff @(posedge CPU_CLK or negedge CPU_RESETn) begin
    if (!CPU_RESETn) begin
      for (int i = 0; i < 6; i++) stage_cnt_q[i] <= '0;
      total_q <= '0;
    end else if (start_acc) begin
      for (int i = 0; i < 6; i++) stage_cnt_q[i] <= '0;
      total_q <= '0;
    end else begin
      if ((state_q == ST_REQ) && (stage_cnt_q[stg_q] != '1))
        stage_cnt_q[stg_q] <= stage_cnt_q[stg_q] + 1'b1;
      if ((state_q != ST_IDLE) && (total_q != '1))
        total_q <= total_q + 1'b1;
    end
  end

  // Counter read mux; select 7 reads zero.
  always_comb begin
    CNT_RDATA = '0;
    if (CNT_SEL < 3'd6)       CNT_RDATA = stage_cnt_q[CNT_SEL];
    else if (CNT_SEL == 3'd6) CNT_RDATA = total_q;
  end

  assign TOTAL_CYCLES = total_q;
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^CNT_SEL;
  assign CNT_RDATA      = '0;
  assign TOTAL_CYCLES   = '0;
`endif

endmodule

// File: tb/tb_app_stage_sequencer.sv
// Bench for app_stage_sequencer: directed runs plus randomized runs against a stage-list model.
// Each run is modelled as a list of per-cycle expectations built from skip mask, engine delays and limit.
// Engines answer by observing STEP_REQ; unrelated STEP_DONE bits are driven with random noise.
module tb_app_stage_sequencer;

  localparam int CNT_W = 32;
  localparam int TMO_W = 24;

  logic             CPU_CLK;
  logic             CPU_RESETn;
  logic             START;
  logic             ABORT;
  logic [5:0]       SKIP_MASK;
  logic [TMO_W-1:0] TIMEOUT_LIMIT;
  logic [5:0]       STEP_REQ;
  logic [5:0]       STEP_DONE;
  logic             BUSY;
  logic             DONE;
  logic             ERROR;
  logic [2:0]       ERR_STAGE;
  logic [2:0]       STAGE;
  logic [2:0]       CNT_SEL;
  logic [CNT_W-1:0] CNT_RDATA;
  logic [CNT_W-1:0] TOTAL_CYCLES;

  app_stage_sequencer #(.CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RESETn(CPU_RESETn), .START(START), .ABORT(ABORT),
    .SKIP_MASK(SKIP_MASK), .TIMEOUT_LIMIT(TIMEOUT_LIMIT), .STEP_REQ(STEP_REQ),
    .STEP_DONE(STEP_DONE), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_STAGE(ERR_STAGE), .STAGE(STAGE), .CNT_SEL(CNT_SEL),
    .CNT_RDATA(CNT_RDATA), .TOTAL_CYCLES(TOTAL_CYCLES)
  );

  initial CPU_CLK = 1'b0;
  always #10 CPU_CLK = ~CPU_CLK;

  typedef struct {
    logic [5:0] req;
    logic       busy;
    logic       done;
    int         stage;
  } cyc_t;

  int n_assert = 0;
  int n_fail   = 0;

  // Engine behaviour for the next run: done arrives dly[k] cycles after REQ[k] rises.
  int dly[6];
  int hang      = -1;
  int abort_stg = -1;

  // Expected sticky error state across runs.
  logic       exp_error     = 1'b0;
  logic [2:0] exp_err_stage = 3'd0;
  int         last_total    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic check_counters(input string name, input int cnt[6], input int total);
    int exp;
    for (int sel = 0; sel < 8; sel++) begin
      CNT_SEL = 3'(sel);
      #1;
`ifdef APP_SEQ_PERF_CNT_EN
      exp = (sel < 6) ? cnt[sel] : ((sel == 6) ? total : 0);
`else
      exp = 0;
`endif
      chk($sformatf("%s cnt_rdata sel%0d", name, sel), CNT_RDATA, 32'(exp));
    end
`ifdef APP_SEQ_PERF_CNT_EN
    chk({name, " total_cycles"}, TOTAL_CYCLES, 32'(total));
`else
    chk({name, " total_cycles"}, TOTAL_CYCLES, 32'd0);
`endif
  endtask

  task automatic do_run(input string name, input logic [5:0] mask, input int limit);
    cyc_t       q[$];
    cyc_t       e;
    int         cnt[6];
    bit         tmo;
    bit         abt;
    int         fstage;
    int         n;
    int         len;
    int         age;
    logic [5:0] prev;
    logic [5:0] dn;
    logic       ab;

    // Model: walk the unskipped stages and lay out the expected cycles.
    tmo = 0; abt = 0; fstage = 0;
    for (int k = 0; k < 6; k++) cnt[k] = 0;
    for (int k = 0; k < 6; k++) begin
      if (mask[k]) continue;
      n   = (k == hang) ? (1 << 30) : dly[k] + 1;
      len = (limit != 0 && n > limit) ? limit : n;
      cnt[k] = len;
      for (int c = 0; c < len; c++) begin
        e.req = 6'b000001 << k; e.busy = 1'b1; e.done = 1'b0; e.stage = k;
        q.push_back(e);
      end
      if (limit != 0 && n > limit) begin tmo = 1; fstage = k; break; end
      if (k == abort_stg) begin abt = 1; break; end
      e.req = 6'b000000; e.busy = 1'b1; e.done = 1'b0; e.stage = -1;
      q.push_back(e);
    end
    if (!tmo && !abt) begin
      e.req = 6'b000000; e.busy = 1'b1; e.done = 1'b1; e.stage = -1;
      q.push_back(e);
    end
    if (tmo) begin exp_error = 1'b1; exp_err_stage = 3'(fstage); end
    else if (abt) begin exp_error = 1'b1; exp_err_stage = 3'd7; end
    else exp_error = 1'b0;

    // Stimulus: accept START, then play the engines while checking every cycle.
    SKIP_MASK = mask; TIMEOUT_LIMIT = TMO_W'(limit); START = 1'b1;
    cycle();
    prev = 6'b000000; age = 0;
    foreach (q[i]) begin
      chk($sformatf("%s c%0d step_req", name, i), 32'(STEP_REQ), 32'(q[i].req));
      chk($sformatf("%s c%0d busy", name, i), 32'(BUSY), 32'(q[i].busy));
      chk($sformatf("%s c%0d done", name, i), 32'(DONE), 32'(q[i].done));
      chk($sformatf("%s c%0d error", name, i), 32'(ERROR), 32'd0);
      if (q[i].stage >= 0) chk($sformatf("%s c%0d stage", name, i), 32'(STAGE), 32'(q[i].stage));
      if (STEP_REQ != prev) age = 0; else age++;
      prev = STEP_REQ;
      dn = 6'($urandom) & ~STEP_REQ;
      ab = 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (STEP_REQ[k] && k != hang && age == dly[k]) begin
          dn[k] = 1'b1;
          if (k == abort_stg) ab = 1'b1;
        end
      end
      STEP_DONE = dn; ABORT = ab;
      START = 1'($urandom_range(0, 1));
      SKIP_MASK = 6'($urandom);
      TIMEOUT_LIMIT = TMO_W'($urandom_range(1, 3));
      cycle();
    end
    START = 1'b0; STEP_DONE = 6'b000000; ABORT = 1'b0;

    // Back in IDLE: flags, error report and counters.
    chk({name, " end busy"}, 32'(BUSY), 32'd0);
    chk({name, " end step_req"}, 32'(STEP_REQ), 32'd0);
    chk({name, " end done"}, 32'(DONE), 32'd0);
    chk({name, " end stage"}, 32'(STAGE), 32'd7);
    chk({name, " end error"}, 32'(ERROR), 32'(exp_error));
    chk({name, " end err_stage"}, 32'(ERR_STAGE), 32'(exp_err_stage));
    last_total = q.size();
    check_counters(name, cnt, q.size());
    cycle();
    check_counters({name, " hold"}, cnt, q.size());
    hang = -1; abort_stg = -1;
  endtask

  initial begin
    int lim;
    CPU_RESETn = 1'b0; START = 1'b0; ABORT = 1'b0; SKIP_MASK = 6'b000000;
    TIMEOUT_LIMIT = '0; STEP_DONE = 6'b000000; CNT_SEL = 3'd0;
    cycle(); cycle();

    // Reset state.
    chk("rst step_req", 32'(STEP_REQ), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst done", 32'(DONE), 32'd0);
    chk("rst error", 32'(ERROR), 32'd0);
    chk("rst err_stage", 32'(ERR_STAGE), 32'd0);
    chk("rst stage", 32'(STAGE), 32'd7);
    chk("rst total", TOTAL_CYCLES, 32'd0);
    CPU_RESETn = 1'b1;
    cycle(); cycle();

    // All stages, done 3 cycles after REQ rises.
    dly = '{3, 3, 3, 3, 3, 3};
    do_run("all", 6'b000000, 0);
`ifdef APP_SEQ_PERF_CNT_EN
    chk("all total31", TOTAL_CYCLES, 32'd31);
`else
    chk("all total31", TOTAL_CYCLES, 32'd0);
`endif

    // Alternate stages skipped.
    dly = '{2, 2, 2, 2, 2, 2};
    do_run("skip", 6'b010101, 0);

    // Stage 2 hangs with limit 5.
    dly = '{1, 2, 0, 1, 1, 1};
    hang = 2;
    do_run("tmo", 6'b000000, 5);

    // Done on the same cycle the watchdog expires; also clears the earlier error.
    dly = '{3, 3, 3, 0, 2, 1};
    do_run("tmo_tie", 6'b000000, 4);

    // Abort with done on stage 4, START pulses while busy.
    dly = '{1, 0, 2, 1, 3, 1};
    abort_stg = 4;
    do_run("abort", 6'b000000, 0);

    // Everything skipped: FIN only.
    dly = '{0, 0, 0, 0, 0, 0};
    do_run("allskip", 6'b111111, 0);
    chk("allskip busy_cycles", 32'(last_total), 32'd1);

    // Randomized runs.
    for (int r = 0; r < 24; r++) begin
      for (int k = 0; k < 6; k++) dly[k] = $urandom_range(0, 5);
      lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 6);
      hang = (lim != 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
      abort_stg = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1;
      do_run($sformatf("rnd%0d", r), 6'($urandom), lim);
    end

    // Reset in the middle of a stage.
    dly = '{9, 9, 9, 9, 9, 9};
    abort_stg = 4;
    do_run("pre_rst", 6'b000000, 0);
    SKIP_MASK = 6'b000000; TIMEOUT_LIMIT = '0; START = 1'b1;
    cycle();
    START = 1'b0;
    cycle(); cycle();
    chk("mid busy before rst", 32'(BUSY), 32'd1);
    chk("mid step_req before rst", 32'(STEP_REQ), 32'd1);
    CPU_RESETn = 1'b0;
    #2;
    chk("arst step_req", 32'(STEP_REQ), 32'd0);
    chk("arst busy", 32'(BUSY), 32'd0);
    chk("arst done", 32'(DONE), 32'd0);
    chk("arst error", 32'(ERROR), 32'd0);
    chk("arst err_stage", 32'(ERR_STAGE), 32'd0);
    chk("arst stage", 32'(STAGE), 32'd7);
    chk("arst total", TOTAL_CYCLES, 32'd0);
    cycle();
    CPU_RESETn = 1'b1;
    exp_error = 1'b0; exp_err_stage = 3'd0;
    cycle();
    chk("post_rst busy", 32'(BUSY), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
